// File: rtl/bp_pkg.sv
// Shared definitions for the perceptron branch-predictor blocks.
//   - default parameter values for the weight store
//   - FSM state encoding of the weight store
//   - sat_step(): saturating +/-1 step on a signed weight of a given width
package bp_pkg;

    localparam int DEF_PERCEPTRON_NUMBER = 64;
    localparam int DEF_HISTORY_SIZE      = 64;
    localparam int DEF_WIDTH             = 8;
    localparam int DEF_SUM_WIDTH         = DEF_WIDTH + $clog2(DEF_HISTORY_SIZE + 1) + 1;
    localparam int DEF_THETA             = 137;   // floor(1.93*64 + 14)

    typedef enum logic [1:0] {
        ST_INIT     = 2'd0,
        ST_IDLE     = 2'd1,
        ST_TRAIN_RD = 2'd2,
        ST_TRAIN_WR = 2'd3
    } state_t;

    // Weight arrives sign-extended to 32 bits; width gives the saturation
    // bounds so one function serves any WIDTH instantiation.
    function automatic logic signed [31:0] sat_step(input logic signed [31:0] w,
                                                    input logic              up,
                                                    input int                width);
        logic signed [31:0] hi;
        logic signed [31:0] lo;
        hi = (32'sd1 <<< (width - 1)) - 32'sd1;
        lo = -hi - 32'sd1;
        if (up) sat_step = (w >= hi) ? hi : w + 32'sd1;
        else    sat_step = (w <= lo) ? lo : w - 32'sd1;
    endfunction

endpackage

// File: rtl/perceptron_row_update.sv
// Combinational perceptron row update.
//   i_row   : current row, element 0 = bias, element i = weight for history bit i-1
//   i_hist  : history snapshot used when the prediction was made
//   i_taken : resolved branch direction
//   o_row   : row after one saturating +/-1 training step
module perceptron_row_update
    import bp_pkg::*;
#(
    parameter int HISTORY_SIZE = DEF_HISTORY_SIZE,
    parameter int WIDTH        = DEF_WIDTH
) (
    input  logic [HISTORY_SIZE:0][WIDTH-1:0] i_row,
    input  logic [HISTORY_SIZE-1:0]          i_hist,
    input  logic                             i_taken,
    output logic [HISTORY_SIZE:0][WIDTH-1:0] o_row
);

    // Bias follows the outcome directly.
    assign o_row[0] = WIDTH'(sat_step(32'(signed'(i_row[0])), i_taken, WIDTH));

    // History weights move toward agreement between history bit and outcome.
    for (genvar gi = 1; gi <= HISTORY_SIZE; gi++) begin : g_w
        assign o_row[gi] = WIDTH'(sat_step(32'(signed'(i_row[gi])),
                                           i_hist[gi-1] ~^ i_taken, WIDTH));
    end

endmodule

// File: rtl/perceptron_weight_store.sv
// Perceptron weight table with in-block threshold-gated training.
//   clk, rst        : clock, synchronous active-high reset
//   pred_en/index   : row read request; pred_valid/pred_weights one cycle later
//   train_*         : valid/ready training request (index, history, taken, sum)
//   init_done       : table cleared after reset
//   train_applied   : one-cycle pulse in the cycle a trained row is written
module perceptron_weight_store
    import bp_pkg::*;
#(
    parameter int PERCEPTRON_NUMBER = DEF_PERCEPTRON_NUMBER,
    parameter int HISTORY_SIZE      = DEF_HISTORY_SIZE,
    parameter int WIDTH             = DEF_WIDTH,
    parameter int SUM_WIDTH         = WIDTH + $clog2(HISTORY_SIZE + 1) + 1,
    parameter int THETA             = DEF_THETA
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic                                 pred_en,
    input  logic [$clog2(PERCEPTRON_NUMBER)-1:0] pred_index,
    output logic                                 pred_valid,
    output logic [HISTORY_SIZE:0][WIDTH-1:0]     pred_weights,
    input  logic                                 train_valid,
    output logic                                 train_ready,
    input  logic [$clog2(PERCEPTRON_NUMBER)-1:0] train_index,
    input  logic [HISTORY_SIZE-1:0]              train_history,
    input  logic                                 train_taken,
    input  logic signed [SUM_WIDTH-1:0]          train_sum,
    output logic                                 init_done,
    output logic                                 train_applied
);

    localparam int IDX_W = $clog2(PERCEPTRON_NUMBER);
    localparam logic signed [SUM_WIDTH-1:0] THETA_S = SUM_WIDTH'(THETA);

    typedef logic [HISTORY_SIZE:0][WIDTH-1:0] row_t;

    row_t                    r_mem [PERCEPTRON_NUMBER];
    state_t                  r_state;
    logic [IDX_W-1:0]        r_clr;
    logic [IDX_W-1:0]        r_idx;
    logic [HISTORY_SIZE-1:0] r_hist;
    logic                    r_taken;
    logic                    r_do_train;
    row_t                    r_old;

    row_t                    w_new;
    logic                    w_gate;
    logic                    w_we;
    logic [IDX_W-1:0]        w_waddr;
    row_t                    w_wdata;

    // Train on a mispredict (sum>=0 means predicted taken) or a low-confidence hit.
    assign w_gate = ((~train_sum[SUM_WIDTH-1]) != train_taken) ||
                    ((train_sum <= THETA_S) && (train_sum >= -THETA_S));

    // Single write port shared by the clear sweep and training.
    assign w_we    = (r_state == ST_INIT) || ((r_state == ST_TRAIN_WR) && r_do_train);
    assign w_waddr = (r_state == ST_INIT) ? r_clr : r_idx;
    assign w_wdata = (r_state == ST_INIT) ? '0 : w_new;

    perceptron_row_update #(
        .HISTORY_SIZE (HISTORY_SIZE),
        .WIDTH        (WIDTH)
    ) u_upd (
        .i_row   (r_old),
        .i_hist  (r_hist),
        .i_taken (r_taken),
        .o_row   (w_new)
    );

    // Storage write; reset blocks a pending TRAIN_WR write.
    always_ff @(posedge clk) begin
        if (!rst && w_we) r_mem[w_waddr] <= w_wdata;
    end

    // Prediction read port. Rows not yet swept during INIT hold stale data, so
    // INIT returns zero; a same-cycle write to the read row is forwarded.
    always_ff @(posedge clk) begin
        if (rst) begin
            pred_valid   <= 1'b0;
            pred_weights <= '0;
        end else begin
            pred_valid <= pred_en;
            if (pred_en) begin
                if (r_state == ST_INIT)                  pred_weights <= '0;
                else if (w_we && w_waddr == pred_index)  pred_weights <= w_wdata;
                else                                     pred_weights <= r_mem[pred_index];
            end
        end
    end

    // Control FSM with registered handshake/status outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= ST_INIT;
            r_clr         <= '0;
            init_done     <= 1'b0;
            train_ready   <= 1'b0;
            train_applied <= 1'b0;
            r_do_train    <= 1'b0;
        end else begin
            case (r_state)
                ST_INIT: begin
                    r_clr <= r_clr + IDX_W'(1);
                    if (r_clr == IDX_W'(PERCEPTRON_NUMBER - 1)) begin
                        r_state     <= ST_IDLE;
                        init_done   <= 1'b1;
                        train_ready <= 1'b1;
                    end
                end
                ST_IDLE: begin
                    if (train_valid && train_ready) begin
                        r_idx       <= train_index;
                        r_hist      <= train_history;
                        r_taken     <= train_taken;
                        r_do_train  <= w_gate;
                        train_ready <= 1'b0;
                        r_state     <= ST_TRAIN_RD;
                    end
                end
                ST_TRAIN_RD: begin
                    r_old         <= r_mem[r_idx];
                    train_applied <= r_do_train;   // high in the write cycle
                    r_state       <= ST_TRAIN_WR;
                end
                ST_TRAIN_WR: begin
                    train_applied <= 1'b0;
                    train_ready   <= 1'b1;
                    r_state       <= ST_IDLE;
                end
                default: r_state <= ST_INIT;
            endcase
        end
    end

endmodule

// File: tb/tb_perceptron_weight_store.sv
module tb_perceptron_weight_store;

    typedef logic [64:0][7:0] row_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        pred_en = 1'b0;
    logic [5:0]  pred_index = '0;
    logic        pred_valid;
    row_t        pred_weights;
    logic        train_valid = 1'b0;
    logic        train_ready;
    logic [5:0]  train_index = '0;
    logic [63:0] train_history = '0;
    logic        train_taken = 1'b0;
    logic signed [15:0] train_sum = '0;
    logic        init_done;
    logic        train_applied;

    perceptron_weight_store dut (
        .clk           (clk),
        .rst           (rst),
        .pred_en       (pred_en),
        .pred_index    (pred_index),
        .pred_valid    (pred_valid),
        .pred_weights  (pred_weights),
        .train_valid   (train_valid),
        .train_ready   (train_ready),
        .train_index   (train_index),
        .train_history (train_history),
        .train_taken   (train_taken),
        .train_sum     (train_sum),
        .init_done     (init_done),
        .train_applied (train_applied)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int   n_cmp = 0;
    int   n_err = 0;
    row_t pq[$];      // expected pred_weights, in issue order
    int   aq[$];      // expected cycle of each train_applied pulse
    int   model [64][65];

    task automatic chk(input string name, input logic [519:0] act, input logic [519:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic row_t mrow(input int idx);
        row_t r;
        for (int i = 0; i < 65; i++) r[i] = 8'(model[idx][i]);
        return r;
    endfunction

    task automatic model_clear();
        for (int r = 0; r < 64; r++)
            for (int i = 0; i < 65; i++) model[r][i] = 0;
    endtask

    // One training step: every weight moves one unit toward the outcome,
    // clamped to the signed 8-bit range.
    task automatic model_train(input int idx, input logic [63:0] h, input logic tk);
        for (int i = 0; i < 65; i++) begin
            bit up;
            up = (i == 0) ? tk : (h[i-1] == tk);
            if (up) model[idx][i] = (model[idx][i] < 127)  ? model[idx][i] + 1 : 127;
            else    model[idx][i] = (model[idx][i] > -128) ? model[idx][i] - 1 : -128;
        end
    endtask

    function automatic bit would_train(input int s, input logic tk);
        bit pt;
        pt = (s >= 0);
        return (pt != tk) || (s >= -137 && s <= 137);
    endfunction

    // Monitor: scoreboard side, independent of the stimulus.
    always @(negedge clk) begin
        if (aq.size() > 0 && aq[0] < cyc) begin
            n_cmp++; n_err++;
            $display("FAIL applied_missing: no pulse, expected at cycle %0d", aq[0]);
            void'(aq.pop_front());
        end
        if (pred_valid) begin
            if (pq.size() == 0) begin
                n_cmp++; n_err++;
                $display("FAIL pred_unexpected: pred_valid=1 with nothing issued (cycle %0d)", cyc);
            end else begin
                chk("pred_weights", pred_weights, pq.pop_front());
            end
        end
        if (train_applied) begin
            if (aq.size() == 0) begin
                n_cmp++; n_err++;
                $display("FAIL applied_unexpected: train_applied=1 expected 0 (cycle %0d)", cyc);
            end else begin
                chk("applied_cycle", cyc, aq.pop_front());
            end
        end
    end

    // All tasks start and end just after a posedge.
    task automatic do_read(input int idx, input bit zero);
        pred_en = 1'b1;
        pred_index = 6'(idx);
        pq.push_back(zero ? row_t'('0) : mrow(idx));
        @(posedge clk); #1;
        pred_en = 1'b0;
    endtask

    task automatic do_reset(input bit already);
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_init_done", init_done, 0);
        chk("rst_train_ready", train_ready, 0);
        chk("rst_pred_valid", pred_valid, 0);
        chk("rst_pred_weights", pred_weights, '0);
        chk("rst_train_applied", train_applied, 0);
        rst = 1'b0;
        model_clear();
        for (int n = 1; n <= 64; n++) begin
            @(posedge clk); #1;
            if (n == 2) begin pred_en = 1'b1; pred_index = 6'd5; pq.push_back('0); end
            if (n == 3) pred_en = 1'b0;
            if (n == 63 || n == 64 || (n % 16) == 0) begin
                chk("init_done_timing", init_done, (n == 64));
                chk("init_train_ready", train_ready, (n == 64));
            end
        end
        if (already) ;
    endtask

    task automatic do_train(input int idx, input logic [63:0] h, input logic tk,
                            input int s, input bit byp, input bit rst_mid);
        bit ok;
        int n;
        train_index = 6'(idx); train_history = h; train_taken = tk;
        train_sum = 16'(s);
        train_valid = 1'b1;
        ok = 1'b0;
        for (int k = 0; k < 300; k++) begin
            @(negedge clk);
            if (train_ready) begin ok = 1'b1; break; end
        end
        if (!ok) begin
            n_cmp++; n_err++;
            $display("FAIL train_ready_timeout: ready=0 expected 1 within 300 cycles");
            @(posedge clk); #1;
            train_valid = 1'b0;
            return;
        end
        n = cyc;
        @(posedge clk); #1;             // TRAIN_RD cycle
        train_valid = 1'b0;
        if (rst_mid) begin rst = 1'b1; return; end
        if (would_train(s, tk)) begin
            aq.push_back(n + 2);
            model_train(idx, h, tk);
        end
        chk("busy_ready_rd", train_ready, 0);
        @(posedge clk); #1;             // TRAIN_WR cycle
        if (byp) begin
            pred_en = 1'b1; pred_index = 6'(idx);
            pq.push_back(mrow(idx));
        end
        @(posedge clk); #1;
        pred_en = 1'b0;
        chk("ready_after_train", train_ready, 1);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        model_clear();
        @(posedge clk); #1;
        do_reset(1'b0);

        // basic training
        do_train(3, '1, 1'b1, 0, 1'b0, 1'b0);
        do_read(3, 1'b0);

        // confident correct prediction: gated off
        do_train(7, {$urandom, $urandom}, 1'b1, 200, 1'b0, 1'b0);
        do_read(7, 1'b0);
        // confident mispredict: trains
        do_train(7, {$urandom, $urandom}, 1'b1, -200, 1'b0, 1'b0);
        do_read(7, 1'b0);
        // threshold boundaries
        do_train(8, {$urandom, $urandom}, 1'b1, 137, 1'b0, 1'b0);
        do_train(8, {$urandom, $urandom}, 1'b1, 138, 1'b0, 1'b0);
        do_train(8, {$urandom, $urandom}, 1'b0, -137, 1'b0, 1'b0);
        do_train(8, {$urandom, $urandom}, 1'b0, -138, 1'b0, 1'b0);
        do_read(8, 1'b0);

        // saturation at the negative bound
        for (int i = 0; i < 130; i++) begin
            do_train(1, '0, 1'b0, 0, 1'b0, 1'b0);
            if (i == 126 || i == 127) do_read(1, 1'b0);
        end
        do_read(1, 1'b0);
        // saturation at the positive bound on the bias via long taken run
        for (int i = 0; i < 129; i++) do_train(4, '1, 1'b1, 0, (i == 128), 1'b0);

        // write-first bypass
        do_train(2, {$urandom, $urandom}, 1'b1, 0, 1'b1, 1'b0);
        do_read(2, 1'b0);

        // randomized mix
        for (int i = 0; i < 60; i++) begin
            int s;
            s = int'($urandom_range(600)) - 300;
            if ($urandom_range(1) == 1) do_read(int'($urandom_range(7)), 1'b0);
            do_train(int'($urandom_range(7)), {$urandom, $urandom}, 1'($urandom_range(1)),
                     s, 1'($urandom_range(1)), 1'b0);
        end
        for (int r = 0; r < 8; r++) do_read(r, 1'b0);

        // reset during TRAIN_RD: abandoned, table cleared again
        do_train(2, '1, 1'b1, 0, 1'b0, 1'b1);
        do_reset(1'b1);
        for (int r = 0; r < 8; r++) do_read(r, 1'b0);
        do_read(63, 1'b0);

        repeat (4) @(posedge clk);
        #1;
        chk("pred_queue_drained", pq.size(), 0);
        chk("applied_queue_drained", aq.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
